arm_pipe_ctrl: RTL and testbench
================================

# arm_pipe_ctrl

Parametrised pipelined control unit for the ARM core, the successor to the fixed 5-stage controller. It decodes the full 16-entry data-processing command set, evaluates all 16 condition codes, and handles BL link writes and LDR/STR with U-bit subtract. It runs a configurable-depth memory pipeline, M1..M`MEM_STAGES`. It sits between the decode register and the datapath/hazard unit, and generates per-stage control from D through W.

## Interface
- `MEM_STAGES`, 1: number of memory pipeline stages, 1..4; the D→W depth is `MEM_STAGES`+2 registers.
- `clk`  in  1  pipeline clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `InstrD`  in  20  instruction bits [31:12] in Decode.
- `ALUFlagsE`  in  4  {N,Z,C,V} from the Execute ALU.
- `FlushE`  in  1  synchronous clear of the E control register; the clear is a bubble.
- `RegSrcD`  out  2  register-read select (STR reads Rd, branch reads PC).
- `ImmSrcD`  out  2  00 DP imm8, 01 mem imm12, 10 branch imm24.
- `LinkD`  out  1  BL: write destination forced to R14.
- `ALUSrcE`  out  1  immediate operand select.
- `ALUControlE`  out  4  ALU command.
- `CarryInE`  out  1  current C flag, for ADC/SBC/RSC.
- `BranchTakenE`  out  1  conditional branch resolved taken.
- `MemtoRegE`  out  1  load in E.
- `MemWriteM`  out  1  gated store in M1.
- `RegWriteM`, `MemtoRegM`  out  1  values in the last M stage.
- `LoadBusy`  out  1  OR of MemtoReg over E..M(`MEM_STAGES`−1); used for load-use stalls.
- `RegWriteW`, `MemtoRegW`, `PCSrcW`, `LinkW`  out  1  values in Writeback.
- `PCWrPendingF`  out  1  PCSrc is present in D, E or any M stage.
- `UndefE`  out  1  E holds an op=11 instruction.
- `FlagsE`  out  4  architectural flag register.

## Operation
- Decode (combinational) on op = `InstrD`[27:26]:
  - 00 DP: `ALUControl` = cmd[24:21]; `ALUSrc` = I[25]; `RegWrite` = 1 except TST/TEQ/CMP/CMN (10xx); those force S = 1.
  - 01 memory: L[20]=1 is LDR (`RegWrite`, `MemtoReg`); L=0 is STR (`MemWrite`, `RegSrc`[1]); `ALUSrc` = 1. `ALUControl` = ADD (0100) if U[23]=1, else SUB (0010).
  - 10 branch: `Branch` = 1, `ALUControl` = ADD. L[24]=1 gives BL: `RegWrite` = 1 and `LinkD` = 1.
  - 11: all controls 0; the undef bit propagates to E.
- `FlagWrite`[1] (N,Z) = S.
- `FlagWrite`[0] (C,V) = S & cmd ∈ {SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN}. It is 0 for non-DP instructions.
- `PCSrcD` = `RegWriteD` & Rd==15 & !`LinkD`.
- Condition evaluation in E uses `FlagsE` and all 16 codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL. NV (1111) = never.
- `CondExE` gates `RegWrite`, `MemWrite`, `PCSrc`, `Branch` and flag update.
- Flag register: a nibble is updated at the end of E only when `CondExE` & the matching `FlagWrite` bit. A bubble or a flushed E never updates the flags.

## Timing
- Reset: every pipeline control register, `FlagsE` and every output = 0, immediately (asynchronous). The first instruction is captured at the first rising edge after reset deasserts.
- Reset mid-operation discards all in-flight control, including pending stores and flag writes.
- Latency: D at cycle t reaches E at t+1, Mk at t+1+k, and W at t+2+`MEM_STAGES`.
- `FlushE` has priority over new D data. `ALUSrcE`, `ALUControlE` and the condition field are not cleared; they are don't-care in a bubble.
- Flush and flag update in the same cycle: the update uses the instruction currently in E; the flush affects only the next E contents.
- Back-to-back flag dependency: an instruction in E sees flags written by the instruction ahead of it (registered at the end of the previous cycle). No combinational forwarding.
- `PCWrPendingF` deasserts the cycle PCSrc reaches W.
- With `MEM_STAGES`=1, M1 is the last M stage and `LoadBusy` = `MemtoRegE`.

## Test plan
- ADDS r1 with result flags {0,1,1,0}, then BEQ (cond 0000) → `BranchTakenE`=1 one cycle after the ADDS is in E; `FlagsE`=0110.
- CMP with flags in {N,Z,C,V} producing 1000, then MOVGE (cond 1010) → `RegWriteW`=0 and `FlagsE`=1000. The MOVGE `RegWrite` is gated.
- LDR with U=0, `MEM_STAGES`=3 → `ALUControlE`=0010. `MemtoRegW`=1 exactly 5 cycles after D. `LoadBusy` is high for 3 cycles.
- BL issued → `LinkD`=1, `LinkW`=`RegWriteW`=1 at t+2+`MEM_STAGES`, `PCSrcW`=0.
- MOV pc, r0 (Rd=15, AL) → `PCWrPendingF` high from D through the last M stage, and `PCSrcW`=1. Asserting `FlushE` on it instead gives `PCSrcW`=0.
- Assert reset low while a STR is in M1 → `MemWriteM`=0 immediately, `FlagsE`=0000.

Source files
------------

// File: rtl/arm_pipe_ctrl.sv
// Pipelined control unit for the ARM core: decodes in D and carries gated control through
// E, a MEM_STAGES-deep memory pipe and W. It also holds the architectural NZCV flags.
module arm_pipe_ctrl #(
    parameter int unsigned MEM_STAGES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] InstrD,
    input  logic [3:0]  ALUFlagsE,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        LinkD,
    output logic        ALUSrcE,
    output logic [3:0]  ALUControlE,
    output logic        CarryInE,
    output logic        BranchTakenE,
    output logic        MemtoRegE,
    output logic        MemWriteM,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic        LoadBusy,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic        LinkW,
    output logic        PCWrPendingF,
    output logic        UndefE,
    output logic [3:0]  FlagsE
);

    logic [1:0] op;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       sBit, isTest;
    logic [1:0] decRegSrc, decImmSrc, decFlagWrite;
    logic [3:0] decAluControl;
    logic       decLink, decRegWrite, decMemWrite, decMemtoReg, decBranch;
    logic       decAluSrc, decUndef, decPcSrc;
    logic       unusedBits;

    assign op  = InstrD[15:14];
    assign cmd = InstrD[12:9];
    assign rd  = InstrD[3:0];
    assign unusedBits = ^InstrD[7:4];

    always_comb begin
        decRegSrc     = 2'b00;
        decImmSrc     = 2'b00;
        decFlagWrite  = 2'b00;
        decAluControl = 4'b0000;
        decLink       = 1'b0;
        decRegWrite   = 1'b0;
        decMemWrite   = 1'b0;
        decMemtoReg   = 1'b0;
        decBranch     = 1'b0;
        decAluSrc     = 1'b0;
        decUndef      = 1'b0;
        sBit          = 1'b0;
        isTest        = 1'b0;
        case (op)
            2'b00: begin
                isTest        = (cmd[3:2] == 2'b10);
                sBit          = InstrD[8] | isTest;
                decAluControl = cmd;
                decAluSrc     = InstrD[13];
                decRegWrite   = ~isTest;
                decFlagWrite[1] = sBit;
                // Arithmetic commands only: SUB..RSC, CMP, CMN
                decFlagWrite[0] = sBit & ((cmd[3:1] == 3'b001) | (cmd[3:1] == 3'b010) |
                                          (cmd[3:1] == 3'b011) | (cmd[3:1] == 3'b101));
            end
            2'b01: begin
                decAluSrc     = 1'b1;
                decImmSrc     = 2'b01;
                decAluControl = InstrD[11] ? 4'b0100 : 4'b0010;
                if (InstrD[8]) begin
                    decRegWrite = 1'b1;
                    decMemtoReg = 1'b1;
                end else begin
                    decMemWrite  = 1'b1;
                    decRegSrc[1] = 1'b1;
                end
            end
            2'b10: begin
                decBranch     = 1'b1;
                decAluSrc     = 1'b1;
                decImmSrc     = 2'b10;
                decRegSrc[0]  = 1'b1;
                decAluControl = 4'b0100;
                decRegWrite   = InstrD[12];
                decLink       = InstrD[12];
            end
            default: decUndef = 1'b1;
        endcase
        decPcSrc = decRegWrite & (rd == 4'hF) & ~decLink;
    end

    // D-stage outputs are combinational, so force them low while reset is held
    assign RegSrcD = reset ? decRegSrc : 2'b00;
    assign ImmSrcD = reset ? decImmSrc : 2'b00;
    assign LinkD   = reset & decLink;

    logic       eRegWrite, eMemWrite, eBranch, ePcSrc, eLink;
    logic [1:0] eFlagWrite;
    logic [3:0] eCond;
    logic       condExE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUSrcE     <= 1'b0;
            ALUControlE <= 4'b0000;
            eCond       <= 4'b0000;
            eRegWrite   <= 1'b0;
            eMemWrite   <= 1'b0;
            MemtoRegE   <= 1'b0;
            eBranch     <= 1'b0;
            ePcSrc      <= 1'b0;
            eLink       <= 1'b0;
            eFlagWrite  <= 2'b00;
            UndefE      <= 1'b0;
        end else begin
            ALUSrcE     <= decAluSrc;
            ALUControlE <= decAluControl;
            eCond       <= InstrD[19:16];
            eRegWrite   <= decRegWrite & ~FlushE;
            eMemWrite   <= decMemWrite & ~FlushE;
            MemtoRegE   <= decMemtoReg & ~FlushE;
            eBranch     <= decBranch & ~FlushE;
            ePcSrc      <= decPcSrc & ~FlushE;
            eLink       <= decLink & ~FlushE;
            eFlagWrite  <= decFlagWrite & {2{~FlushE}};
            UndefE      <= decUndef & ~FlushE;
        end
    end

    logic fN, fZ, fC, fV;
    assign {fN, fZ, fC, fV} = FlagsE;

    always_comb begin
        case (eCond)
            4'h0: condExE = fZ;
            4'h1: condExE = ~fZ;
            4'h2: condExE = fC;
            4'h3: condExE = ~fC;
            4'h4: condExE = fN;
            4'h5: condExE = ~fN;
            4'h6: condExE = fV;
            4'h7: condExE = ~fV;
            4'h8: condExE = fC & ~fZ;
            4'h9: condExE = ~fC | fZ;
            4'hA: condExE = (fN == fV);
            4'hB: condExE = (fN != fV);
            4'hC: condExE = ~fZ & (fN == fV);
            4'hD: condExE = fZ | (fN != fV);
            4'hE: condExE = 1'b1;
            default: condExE = 1'b0;
        endcase
    end

    assign BranchTakenE = eBranch & condExE;
    assign CarryInE     = FlagsE[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FlagsE <= 4'b0000;
        end else begin
            if (condExE & eFlagWrite[1]) FlagsE[3:2] <= ALUFlagsE[3:2];
            if (condExE & eFlagWrite[0]) FlagsE[1:0] <= ALUFlagsE[1:0];
        end
    end

    // Index k holds memory stage M(k+1)
    logic [MEM_STAGES-1:0] mRegWrite, mMemWrite, mMemtoReg, mPcSrc, mLink;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mRegWrite <= '0;
            mMemWrite <= '0;
            mMemtoReg <= '0;
            mPcSrc    <= '0;
            mLink     <= '0;
        end else begin
            for (int k = int'(MEM_STAGES) - 1; k > 0; k--) begin
                mRegWrite[k] <= mRegWrite[k-1];
                mMemWrite[k] <= mMemWrite[k-1];
                mMemtoReg[k] <= mMemtoReg[k-1];
                mPcSrc[k]    <= mPcSrc[k-1];
                mLink[k]     <= mLink[k-1];
            end
            mRegWrite[0] <= eRegWrite & condExE;
            mMemWrite[0] <= eMemWrite & condExE;
            mMemtoReg[0] <= MemtoRegE;
            mPcSrc[0]    <= ePcSrc & condExE;
            mLink[0]     <= eLink;
        end
    end

    assign MemWriteM = mMemWrite[0];
    assign RegWriteM = mRegWrite[MEM_STAGES-1];
    assign MemtoRegM = mMemtoReg[MEM_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
            LinkW     <= 1'b0;
        end else begin
            RegWriteW <= mRegWrite[MEM_STAGES-1];
            MemtoRegW <= mMemtoReg[MEM_STAGES-1];
            PCSrcW    <= mPcSrc[MEM_STAGES-1];
            LinkW     <= mLink[MEM_STAGES-1];
        end
    end

    // The last M stage is excluded: its load result is forwardable by then
    always_comb begin
        LoadBusy = MemtoRegE;
        for (int k = 0; k < int'(MEM_STAGES) - 1; k++) begin
            LoadBusy = LoadBusy | mMemtoReg[k];
        end
    end

    assign PCWrPendingF = (reset & decPcSrc) | ePcSrc | (|mPcSrc);

endmodule

// File: tb/tb_arm_pipe_ctrl.sv
// Scoreboard bench for arm_pipe_ctrl: an instruction-level model predicts every stage's
// outputs per cycle; a separate monitor pops and compares on each falling edge.
module tb_arm_pipe_ctrl;

    localparam int MS = 3;

    localparam logic [19:0] NOP    = 20'hF0000;
    localparam logic [19:0] ADDS   = 20'hE2921;
    localparam logic [19:0] BEQ    = 20'h0A000;
    localparam logic [19:0] CMP    = 20'hE1510;
    localparam logic [19:0] MOVGE  = 20'hA1A03;
    localparam logic [19:0] LDRSUB = 20'hE5112;
    localparam logic [19:0] BL     = 20'hEB000;
    localparam logic [19:0] MOVPC  = 20'hE1A0F;
    localparam logic [19:0] STR    = 20'hE5801;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] InstrD;
    logic [3:0]  ALUFlagsE;
    logic        FlushE;
    logic [1:0]  RegSrcD, ImmSrcD;
    logic        LinkD, ALUSrcE, CarryInE, BranchTakenE, MemtoRegE, MemWriteM;
    logic [3:0]  ALUControlE, FlagsE;
    logic        RegWriteM, MemtoRegM, LoadBusy, RegWriteW, MemtoRegW, PCSrcW, LinkW;
    logic        PCWrPendingF, UndefE;

    always #5 clk = ~clk;

    arm_pipe_ctrl #(.MEM_STAGES(MS)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .LinkD(LinkD), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .CarryInE(CarryInE), .BranchTakenE(BranchTakenE),
        .MemtoRegE(MemtoRegE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .LoadBusy(LoadBusy), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .LinkW(LinkW), .PCWrPendingF(PCWrPendingF),
        .UndefE(UndefE), .FlagsE(FlagsE)
    );

    typedef struct packed {
        logic       valid, regWrite, memWrite, memtoReg, branch, pcSrc, link, undef, aluSrc;
        logic [1:0] fw, regSrc, immSrc;
        logic [3:0] aluCtl, cond;
    } dec_t;

    typedef struct packed {
        logic regWrite, memWrite, memtoReg, pcSrc, link;
    } res_t;

    typedef struct packed {
        logic [3:0] flags;
        logic       carry, brTaken, undef, memtoRegE, aluValid, aluSrc;
        logic [3:0] aluCtl;
        logic       memWriteM, regWriteM, memtoRegM, loadBusy;
        logic       regWriteW, memtoRegW, pcSrcW, linkW, pcPend;
        logic [1:0] regSrcD, immSrcD;
        logic       linkD;
    } exp_t;

    exp_t q[$];
    res_t hist[int];
    dec_t cur;
    logic [3:0] mf;
    int sn;
    int nChk = 0;
    int nPass = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        nChk++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic dec_t decode(input logic [19:0] ins);
        dec_t d;
        logic [3:0] c;
        logic s;
        d = '0;
        c = ins[12:9];
        d.valid = 1'b1;
        d.cond = ins[19:16];
        case (ins[15:14])
            2'b00: begin
                d.aluCtl = c;
                d.aluSrc = ins[13];
                s = ins[8];
                if (c == 4'd8 || c == 4'd9 || c == 4'd10 || c == 4'd11) s = 1'b1;
                else d.regWrite = 1'b1;
                d.fw[1] = s;
                d.fw[0] = s && (c inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11});
            end
            2'b01: begin
                d.aluSrc = 1'b1;
                d.immSrc = 2'b01;
                d.aluCtl = ins[11] ? 4'd4 : 4'd2;
                if (ins[8]) begin d.regWrite = 1'b1; d.memtoReg = 1'b1; end
                else begin d.memWrite = 1'b1; d.regSrc = 2'b10; end
            end
            2'b10: begin
                d.branch = 1'b1;
                d.aluSrc = 1'b1;
                d.immSrc = 2'b10;
                d.regSrc = 2'b01;
                d.aluCtl = 4'd4;
                if (ins[12]) begin d.regWrite = 1'b1; d.link = 1'b1; end
            end
            default: d.undef = 1'b1;
        endcase
        d.pcSrc = d.regWrite && ins[3:0] == 4'hF && !d.link;
        return d;
    endfunction

    function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic res_t getRes(input int j);
        if (hist.exists(j)) return hist[j];
        return '0;
    endfunction

    task automatic modelInit();
        mf = 4'h0;
        hist.delete();
        q.delete();
        cur = decode(NOP);
        sn = 0;
    endtask

    // One clock of stimulus; predicts what the DUT shows on this cycle's falling edge
    task automatic driveCycle(input logic [19:0] ins, input logic fl, input logic [3:0] af);
        exp_t e;
        res_t r;
        dec_t d;
        logic ce;
        @(posedge clk);
        #1;
        InstrD = ins;
        FlushE = fl;
        ALUFlagsE = af;
        d = decode(ins);
        ce = condHolds(cur.cond, mf);
        r.regWrite = cur.regWrite && ce;
        r.memWrite = cur.memWrite && ce;
        r.memtoReg = cur.memtoReg;
        r.pcSrc    = cur.pcSrc && ce;
        r.link     = cur.link;
        hist[sn] = r;
        e = '0;
        e.flags = mf;
        e.carry = mf[1];
        e.brTaken = cur.branch && ce;
        e.undef = cur.undef;
        e.memtoRegE = cur.memtoReg;
        e.aluValid = cur.valid;
        e.aluSrc = cur.aluSrc;
        e.aluCtl = cur.aluCtl;
        e.memWriteM = getRes(sn - 1).memWrite;
        e.regWriteM = getRes(sn - MS).regWrite;
        e.memtoRegM = getRes(sn - MS).memtoReg;
        e.regWriteW = getRes(sn - MS - 1).regWrite;
        e.memtoRegW = getRes(sn - MS - 1).memtoReg;
        e.pcSrcW = getRes(sn - MS - 1).pcSrc;
        e.linkW = getRes(sn - MS - 1).link;
        e.loadBusy = cur.memtoReg;
        for (int k = 1; k < MS; k++) e.loadBusy = e.loadBusy | getRes(sn - k).memtoReg;
        e.pcPend = d.pcSrc | cur.pcSrc;
        for (int k = 1; k <= MS; k++) e.pcPend = e.pcPend | getRes(sn - k).pcSrc;
        e.regSrcD = d.regSrc;
        e.immSrcD = d.immSrc;
        e.linkD = d.link;
        q.push_back(e);
        if (ce && cur.fw[1]) mf[3:2] = af[3:2];
        if (ce && cur.fw[0]) mf[1:0] = af[1:0];
        cur = fl ? dec_t'('0) : d;
        sn++;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, ".RegSrcD"}, {2'b00, RegSrcD}, 4'h0);
        chk({tag, ".ImmSrcD"}, {2'b00, ImmSrcD}, 4'h0);
        chk({tag, ".LinkD"}, {3'b000, LinkD}, 4'h0);
        chk({tag, ".ALUControlE"}, ALUControlE, 4'h0);
        chk({tag, ".FlagsE"}, FlagsE, 4'h0);
        chk({tag, ".MemWriteM"}, {3'b000, MemWriteM}, 4'h0);
        chk({tag, ".ctlE"}, {ALUSrcE, BranchTakenE, MemtoRegE, UndefE}, 4'h0);
        chk({tag, ".ctlM"}, {RegWriteM, MemtoRegM, LoadBusy, PCWrPendingF}, 4'h0);
        chk({tag, ".ctlW"}, {RegWriteW, MemtoRegW, PCSrcW, LinkW}, 4'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("FlagsE", FlagsE, e.flags);
                chk("CarryInE", {3'b000, CarryInE}, {3'b000, e.carry});
                chk("BranchTakenE", {3'b000, BranchTakenE}, {3'b000, e.brTaken});
                chk("UndefE", {3'b000, UndefE}, {3'b000, e.undef});
                chk("MemtoRegE", {3'b000, MemtoRegE}, {3'b000, e.memtoRegE});
                if (e.aluValid) begin
                    chk("ALUControlE", ALUControlE, e.aluCtl);
                    chk("ALUSrcE", {3'b000, ALUSrcE}, {3'b000, e.aluSrc});
                end
                chk("MemWriteM", {3'b000, MemWriteM}, {3'b000, e.memWriteM});
                chk("RegWriteM", {3'b000, RegWriteM}, {3'b000, e.regWriteM});
                chk("MemtoRegM", {3'b000, MemtoRegM}, {3'b000, e.memtoRegM});
                chk("LoadBusy", {3'b000, LoadBusy}, {3'b000, e.loadBusy});
                chk("W", {RegWriteW, MemtoRegW, PCSrcW, LinkW},
                    {e.regWriteW, e.memtoRegW, e.pcSrcW, e.linkW});
                chk("PCWrPendingF", {3'b000, PCWrPendingF}, {3'b000, e.pcPend});
                chk("RegSrcD", {2'b00, RegSrcD}, {2'b00, e.regSrcD});
                chk("ImmSrcD", {2'b00, ImmSrcD}, {2'b00, e.immSrcD});
                chk("LinkD", {3'b000, LinkD}, {3'b000, e.linkD});
            end
        end
    end

    initial begin : driver
        logic [31:0] r;
        logic [19:0] ins;
        reset = 1'b0;
        InstrD = NOP;
        FlushE = 1'b0;
        ALUFlagsE = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("por");
        reset = 1'b1;
        modelInit();

        // ADDS sets Z,C then BEQ; CMP sets N then MOVGE; LDR subtract; BL; MOV pc
        driveCycle(ADDS, 1'b0, 4'h0);
        driveCycle(BEQ, 1'b0, 4'h6);
        driveCycle(NOP, 1'b0, 4'h0);
        driveCycle(CMP, 1'b0, 4'h0);
        driveCycle(MOVGE, 1'b0, 4'h8);
        driveCycle(LDRSUB, 1'b0, 4'h0);
        driveCycle(BL, 1'b0, 4'h0);
        driveCycle(MOVPC, 1'b0, 4'h0);
        repeat (MS + 2) driveCycle(NOP, 1'b0, 4'h0);
        driveCycle(MOVPC, 1'b1, 4'h0);
        repeat (MS + 2) driveCycle(NOP, 1'b0, 4'h0);

        // Reset while a store sits in M1 and the flags are nonzero
        driveCycle(STR, 1'b0, 4'h0);
        driveCycle(NOP, 1'b0, 4'h0);
        driveCycle(NOP, 1'b0, 4'h0);
        @(negedge clk);
        #1;
        InstrD = STR;
        reset = 1'b0;
        #1;
        checkAllZero("midReset");
        InstrD = NOP;
        FlushE = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        modelInit();

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            ins = r[19:0];
            if ($urandom_range(0, 3) == 0) ins[19:16] = 4'hE;
            if ($urandom_range(0, 7) == 0) ins[3:0] = 4'hF;
            if (ins[15:14] == 2'b11 && $urandom_range(0, 1) == 0) ins[15:14] = 2'b00;
            r = $urandom;
            driveCycle(ins, ($urandom_range(0, 9) == 0), r[3:0]);
        end
        repeat (MS + 3) driveCycle(NOP, 1'b0, 4'h0);
        @(negedge clk);
        #1;
        chk("queueDrained", {3'b000, (q.size() == 0)}, 4'h1);
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
